// File: rtl/led_response_monitor.sv
// led_response_monitor: measures the PMT light response to each LED flash
// (edge-to-crossing latency, peak and saturating charge over WINDOW samples)
// and hands the result to slow control through a VALID/ACK handshake.
// Ports: CLK120/RESET (sync, active-high); LED strobe and ADC sample (both
// registered on entry); BASELINE/THRESHOLD/TIMEOUT configuration;
// RESULT_ACK in; RESULT_* out; MISSED_COUNT and BUSY status.
// Optional: define LED_MON_AUTO_BASELINE_EN to replace BASELINE with the mean
// of the 16 idle samples that precede each edge.
module led_response_monitor #(
  parameter int ADC_WIDTH    = 12,
  parameter int LAT_WIDTH    = 10,
  parameter int WINDOW       = 64,
  parameter int CHARGE_WIDTH = 20
) (
  input  logic                    CLK120,
  input  logic                    RESET,
  input  logic                    LED,
  input  logic [ADC_WIDTH-1:0]    ADC,
  input  logic [ADC_WIDTH-1:0]    BASELINE,
  input  logic [ADC_WIDTH-1:0]    THRESHOLD,
  input  logic [LAT_WIDTH-1:0]    TIMEOUT,
  input  logic                    RESULT_ACK,
  output logic                    RESULT_VALID,
  output logic [LAT_WIDTH-1:0]    RESULT_LATENCY,
  output logic [ADC_WIDTH-1:0]    RESULT_PEAK,
  output logic [CHARGE_WIDTH-1:0] RESULT_CHARGE,
  output logic                    RESULT_TIMEOUT,
  output logic [7:0]              MISSED_COUNT,
  output logic                    BUSY
);

  typedef enum logic [1:0] {IDLE, SEARCH, INTEG, DONE} state_t;

  state_t                 state, state_nxt;
  logic                   led_r, prev_led;
  logic [ADC_WIDTH-1:0]   adc_r;
  logic [LAT_WIDTH-1:0]   lat_cnt, lat_now;
  logic [7:0]             win_cnt;
  logic                   edge_det, searching, hit, expire;
  logic                   do_hit, do_timeout, do_acc, miss;
  logic [ADC_WIDTH-1:0]   base_eff, s;
  logic [CHARGE_WIDTH:0]  charge_sum;
  logic [CHARGE_WIDTH-1:0] charge_sat;

  assign edge_det = led_r & ~prev_led;
  assign BUSY     = (state != IDLE);

`ifdef LED_MON_AUTO_BASELINE_EN
  logic [ADC_WIDTH-1:0] hist [16];
  logic [ADC_WIDTH+3:0] hist_sum;
  logic [ADC_WIDTH-1:0] base_lat;
  logic                 unused_baseline;

  assign unused_baseline = ^BASELINE;
  // While idle the live history mean is used so the edge-cycle check sees the
  // same pedestal that gets latched for the rest of the measurement.
  assign base_eff = (state == IDLE) ? hist_sum[ADC_WIDTH+3:4] : base_lat;

  always_ff @(posedge CLK120) begin
    if (RESET) begin
      for (int i = 0; i < 16; i++) hist[i] <= '0;
      hist_sum <= '0;
      base_lat <= '0;
    end else if (state == IDLE) begin
      for (int i = 15; i > 0; i--) hist[i] <= hist[i-1];
      hist[0]  <= adc_r;
      hist_sum <= hist_sum + (ADC_WIDTH+4)'(adc_r) - (ADC_WIDTH+4)'(hist[15]);
      if (edge_det) base_lat <= hist_sum[ADC_WIDTH+3:4];
    end
  end
`else
  assign base_eff = BASELINE;
`endif

  assign s = (adc_r > base_eff) ? (adc_r - base_eff) : '0;

  // The edge cycle is searched from IDLE with an implicit LAT_CNT of 0.
  assign searching = (state == SEARCH) || ((state == IDLE) && edge_det);
  assign lat_now   = (state == IDLE) ? '0 : lat_cnt;
  assign hit       = (s >= THRESHOLD);
  assign expire    = (lat_now == TIMEOUT);
  assign miss      = edge_det && (state != IDLE);

  assign charge_sum = {1'b0, RESULT_CHARGE} + (CHARGE_WIDTH+1)'(s);
  assign charge_sat = charge_sum[CHARGE_WIDTH] ? '1 : charge_sum[CHARGE_WIDTH-1:0];

  always_comb begin
    state_nxt  = state;
    do_hit     = 1'b0;
    do_timeout = 1'b0;
    do_acc     = 1'b0;
    if (searching) begin
      if (hit) begin
        do_hit    = 1'b1;
        state_nxt = (WINDOW == 1) ? DONE : INTEG;
      end else if (expire) begin
        do_timeout = 1'b1;
        state_nxt  = DONE;
      end else begin
        state_nxt = SEARCH;
      end
    end else if (state == INTEG) begin
      do_acc = 1'b1;
      if (win_cnt == 8'(WINDOW - 1)) state_nxt = DONE;
    end else if (state == DONE) begin
      if (RESULT_ACK) state_nxt = IDLE;
    end
  end

  always_ff @(posedge CLK120) begin
    if (RESET) begin
      state          <= IDLE;
      led_r          <= 1'b0;
      prev_led       <= 1'b0;
      adc_r          <= '0;
      lat_cnt        <= '0;
      win_cnt        <= '0;
      RESULT_VALID   <= 1'b0;
      RESULT_LATENCY <= '0;
      RESULT_PEAK    <= '0;
      RESULT_CHARGE  <= '0;
      RESULT_TIMEOUT <= 1'b0;
      MISSED_COUNT   <= '0;
    end else begin
      state        <= state_nxt;
      led_r        <= LED;
      prev_led     <= led_r;
      adc_r        <= ADC;
      RESULT_VALID <= (state_nxt == DONE);

      if (miss && (MISSED_COUNT != 8'hFF)) MISSED_COUNT <= MISSED_COUNT + 8'd1;

      if (do_hit) begin
        RESULT_LATENCY <= lat_now;
        RESULT_PEAK    <= s;
        RESULT_CHARGE  <= CHARGE_WIDTH'(s);
        win_cnt        <= 8'd1;
      end else if (do_timeout) begin
        RESULT_TIMEOUT <= 1'b1;
        RESULT_LATENCY <= TIMEOUT;
        RESULT_PEAK    <= '0;
        RESULT_CHARGE  <= '0;
      end else if (searching) begin
        lat_cnt <= lat_now + 1'b1;
      end

      if (do_acc) begin
        RESULT_CHARGE <= charge_sat;
        if (s > RESULT_PEAK) RESULT_PEAK <= s;
        win_cnt <= win_cnt + 8'd1;
      end

      if ((state == DONE) && RESULT_ACK) RESULT_TIMEOUT <= 1'b0;
    end
  end

endmodule

// File: tb/tb_led_response_monitor.sv
module tb_led_response_monitor;
  localparam int AW   = 12;
  localparam int LW   = 10;
  localparam int WIN  = 4;
  localparam int CW   = 12;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk  = 1'b0;
  logic          rst  = 1'b1;
  logic          led  = 1'b0;
  logic          ack  = 1'b0;
  logic [AW-1:0] adc  = '0;
  logic [AW-1:0] base = '0;
  logic [AW-1:0] th   = '0;
  logic [LW-1:0] tmo  = '0;
  logic          rvalid, rtmo, busy;
  logic [LW-1:0] rlat;
  logic [AW-1:0] rpeak;
  logic [CW-1:0] rchg;
  logic [7:0]    missed;

  always #4 clk = ~clk;

  led_response_monitor #(.ADC_WIDTH(AW), .LAT_WIDTH(LW), .WINDOW(WIN), .CHARGE_WIDTH(CW)) dut (
    .CLK120(clk), .RESET(rst), .LED(led), .ADC(adc), .BASELINE(base), .THRESHOLD(th),
    .TIMEOUT(tmo), .RESULT_ACK(ack), .RESULT_VALID(rvalid), .RESULT_LATENCY(rlat),
    .RESULT_PEAK(rpeak), .RESULT_CHARGE(rchg), .RESULT_TIMEOUT(rtmo),
    .MISSED_COUNT(missed), .BUSY(busy)
  );

  int n_checks   = 0;
  int n_fail     = 0;
  int exp_missed = 0;
  int e_lat, e_pk, e_chg, e_tof;
  int hist [16];
  bit m_idle = 1'b1;
  int smp [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sub(input int a, input int b);
    return (a > b) ? a - b : 0;
  endfunction

  function automatic int hist_avg();
    int sum = 0;
    foreach (hist[i]) sum += hist[i];
    return sum >> 4;
  endfunction

  function automatic void push(input int v);
    for (int i = 15; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = v;
  endfunction

  // Drive one sample per falling edge; also track the idle-sample history.
  task automatic drv(input logic l, input int a, input logic k, input logic r);
    @(negedge clk);
    led = l; adc = AW'(a); ack = k; rst = r;
    if (r) begin
      foreach (hist[i]) hist[i] = 0;
      push(0);
      m_idle = 1'b1;
    end else if (m_idle) begin
      push(a);
    end
  endtask

  // Transaction-level expectation for one flash whose edge sample is smp[0].
  function automatic void model(input int b, output int lat, output int pk, output int chg,
                                output int tof, output int cyc);
    bit found = 1'b0;
    lat = int'(tmo); pk = 0; chg = 0; tof = 1; cyc = int'(tmo) + 1;
    for (int k = 0; k <= int'(tmo) && !found; k++) begin
      if (sub(smp[k], b) >= int'(th)) begin
        found = 1'b1; lat = k; tof = 0; cyc = k + WIN;
        for (int i = k; i < k + WIN; i++) begin
          chg += sub(smp[i], b);
          if (sub(smp[i], b) > pk) pk = sub(smp[i], b);
        end
        if (chg > CMAX) chg = CMAX;
      end
    end
  endfunction

  task automatic fill(input int v);
    smp.delete();
    for (int i = 0; i < int'(tmo) + WIN + 2; i++) smp.push_back(v);
  endtask

  task automatic measure(input int led_len, input bit ack_first, input int abort_at);
    int lat, pk, chg, tof, cyc, b, got;
    got = -1;
    if (led) drv(1'b0, int'(base), 1'b0, 1'b0);
`ifdef LED_MON_AUTO_BASELINE_EN
    b = hist_avg();
`else
    b = int'(base);
`endif
    if (ack_first) m_idle = 1'b1;
    drv(1'b1, smp[0], ack_first, 1'b0);
    m_idle = 1'b0;
    model(b, lat, pk, chg, tof, cyc);
    for (int j = 0; j < 700 && got < 0; j++) begin
      if (j == abort_at) begin
        drv(1'b0, 0, 1'b0, 1'b1);
        drv(1'b0, 0, 1'b0, 1'b0);
        exp_missed = 0;
        check("abort_valid", rvalid, 0);
        check("abort_latency", rlat, 0);
        check("abort_peak", rpeak, 0);
        check("abort_charge", rchg, 0);
        check("abort_missed", missed, 0);
        check("abort_busy", busy, 0);
        return;
      end
      drv(j + 1 < led_len, (j + 1 < smp.size()) ? smp[j+1] : 0, 1'b0, 1'b0);
      if (j == 1) check("busy_meas", busy, 1);
      if (rvalid === 1'b1) got = j;
    end
    check("valid_time", got, cyc);
    check("latency", rlat, lat);
    check("peak", rpeak, pk);
    check("charge", rchg, chg);
    check("timeout_flag", rtmo, tof);
    e_lat = lat; e_pk = pk; e_chg = chg; e_tof = tof;
  endtask

  task automatic hold_and_ack(input int n_hold, input int n_edges, input bit edge_with_ack);
    int unstable = 0;
    for (int i = 0; i < n_hold; i++) begin
      logic l;
      l = (i < 2 * n_edges) && (i % 2 == 1);
      if (l && !led && exp_missed < 255) exp_missed++;
      drv(l, int'($urandom_range(0, 4095)), 1'b0, 1'b0);
      if (rvalid !== 1'b1 || int'(rlat) != e_lat || int'(rpeak) != e_pk ||
          int'(rchg) != e_chg || int'(rtmo) != e_tof || busy !== 1'b1) unstable++;
    end
    check("hold_stable", unstable, 0);
    if (edge_with_ack) begin
      drv(1'b0, 0, 1'b0, 1'b0);
      drv(1'b1, 0, 1'b0, 1'b0);
      if (exp_missed < 255) exp_missed++;
    end
    m_idle = 1'b1;
    drv(led, int'(base), 1'b1, 1'b0);
    drv(led, int'(base), 1'b0, 1'b0);
    check("ack_valid", rvalid, 0);
    check("ack_busy", busy, 0);
    check("ack_timeout", rtmo, 0);
    check("ack_lat_hold", rlat, e_lat);
    check("ack_peak_hold", rpeak, e_pk);
    check("ack_chg_hold", rchg, e_chg);
    check("missed", missed, exp_missed);
  endtask

  task automatic basic_pulse();
    fill(100);
    smp[5] = 200; smp[6] = 300; smp[7] = 250; smp[8] = 120;
  endtask

  initial begin
    int hi;
    drv(1'b0, 0, 1'b0, 1'b1);
    drv(1'b0, 0, 1'b0, 1'b1);
    check("rst_valid", rvalid, 0);
    check("rst_latency", rlat, 0);
    check("rst_peak", rpeak, 0);
    check("rst_charge", rchg, 0);
    check("rst_timeout", rtmo, 0);
    check("rst_missed", missed, 0);
    check("rst_busy", busy, 0);
    drv(1'b0, 0, 1'b0, 1'b0);

    base = 100; th = 50; tmo = 20;
    basic_pulse();
    measure(2, 1'b0, -1);
`ifndef LED_MON_AUTO_BASELINE_EN
    check("basic_lat", rlat, 5);
    check("basic_peak", rpeak, 200);
    check("basic_charge", rchg, 470);
`endif
    hold_and_ack(100, 1, 1'b0);
    check("handshake_missed", missed, 1);

    tmo = 10; fill(100);
    measure(3, 1'b0, -1);
`ifndef LED_MON_AUTO_BASELINE_EN
    check("tmo_lat", rlat, 10);
    check("tmo_flag", rtmo, 1);
`endif
    hold_and_ack(4, 0, 1'b1);
    hi = 0;
    repeat (3) begin
      drv(1'b1, 100, 1'b0, 1'b0);
      if (busy !== 1'b0) hi++;
    end
    check("held_led_no_retrigger", hi, 0);

    tmo = 20; basic_pulse();
    measure(2, 1'b0, -1);
    fill(100); smp[2] = 400;
    measure(1, 1'b1, -1);
    hold_and_ack(2, 0, 1'b0);

    base = 0; th = 100; tmo = 5; fill(4095);
    measure(2, 1'b0, -1);
`ifndef LED_MON_AUTO_BASELINE_EN
    check("sat_charge", rchg, 4095);
    check("sat_peak", rpeak, 4095);
`endif
    hold_and_ack(1, 0, 1'b0);

    base = 100; th = 50; tmo = 20; basic_pulse();
    measure(1, 1'b0, 6);
    measure(2, 1'b0, -1);
    hold_and_ack(0, 0, 1'b0);

`ifdef LED_MON_AUTO_BASELINE_EN
    base = 0; th = 20; tmo = 8;
    repeat (16) drv(1'b0, 80, 1'b0, 1'b0);
    fill(110);
    measure(1, 1'b0, -1);
    check("auto_lat", rlat, 0);
    check("auto_peak", rpeak, 30);
    hold_and_ack(0, 0, 1'b0);
`endif

    repeat (40) begin
      base = AW'($urandom_range(0, 600));
      th   = AW'($urandom_range(0, 400));
      tmo  = LW'($urandom_range(0, 25));
      fill(0);
      foreach (smp[i])
        smp[i] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 4095))
                                              : int'($urandom_range(0, int'(base) + int'(th)));
      repeat ($urandom_range(0, 3)) drv(1'b0, int'($urandom_range(0, 4095)), 1'b0, 1'b0);
      measure(int'($urandom_range(1, 8)), 1'b0, -1);
      hold_and_ack(int'($urandom_range(0, 6)), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    base = 100; th = 50; tmo = 20; basic_pulse();
    measure(2, 1'b0, -1);
    hold_and_ack(530, 260, 1'b0);
    check("missed_saturate", missed, 255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
